bsg_sync_filter: RTL
====================

# bsg_sync_filter

Single-clock, multi-channel input conditioner for asynchronous level signals such as pins, straps and foreign-domain status bits. Each channel passes through a parametrised-depth synchronizer chain, then a per-channel glitch filter. A channel's output changes only after its synchronized input has held a new value for a programmable number of consecutive cycles. Registered one-cycle rise/fall pulses accompany every accepted change. The block sits at the boundary between asynchronous sources and a `clk_i` consumer, in place of a bare launch/sync pair.

## Interface
- `width_p`, default 8: number of independent channels.
- `sync_stages_p`, default 2: synchronizer flops per channel; legal range ≥ 2.
- `filter_cycles_p`, default 4: consecutive stable cycles required to accept a change; legal range ≥ 1.
- `clk_i` input, 1 bit: sole clock; all state updates on its rising edge.
- `reset_i` input, 1 bit: reset, synchronous and active-high.
- `async_i` input, `width_p` bits: asynchronous level inputs; no timing relation to `clk_i`.
- `data_o` output, `width_p` bits: filtered, synchronized level per channel.
- `rise_o` output, `width_p` bits: one-cycle pulse when `data_o[i]` goes 0→1.
- `fall_o` output, `width_p` bits: one-cycle pulse when `data_o[i]` goes 1→0.
- `evt_o` output, `width_p` bits: present only under the configuration macro; sticky change flags.
- `evt_clr_i` input, `width_p` bits: present only under the configuration macro; per-bit clear of `evt_o`.

## Operation
- Per-channel state:
  - Sync chain `s[0..sync_stages_p-1]`; `s[0]` samples `async_i[i]`, `s[k]` samples `s[k-1]`. Let `y = s[sync_stages_p-1]`.
  - Counter `cnt`, width `$clog2(filter_cycles_p+1)`.
  - Level register `data_o[i]`.
  - Pulse registers `rise_o[i]` and `fall_o[i]`.
- Per-edge behaviour for each channel, two states:
  - STABLE (`y == data_o[i]`): `cnt <= 0`.
  - PENDING (`y != data_o[i]`):
    - If `cnt == filter_cycles_p-1`: `data_o[i] <= y`, `cnt <= 0`, and `rise_o[i] <= y` / `fall_o[i] <= ~y`.
    - Otherwise: `cnt <= cnt+1`.
  - `rise_o[i]` and `fall_o[i]` deassert on every edge that does not accept a change.
- Glitch rejection: if `y` returns to `data_o[i]` before acceptance, the channel goes STABLE, `cnt` clears, and no output changes. Pulses shorter than `filter_cycles_p` cycles at `y` are discarded.
- The counter never exceeds `filter_cycles_p-1`; no wrap-around is possible.
- `filter_cycles_p == 1`: `data_o` follows `y` with one cycle of delay; the counter is held at 0.
- Channels are fully independent; simultaneous changes on several channels are each accepted on their own schedule.
- `rise_o[i]` and `fall_o[i]` are never high together.
- Reset:
  - While `reset_i` is high at an edge, all `s`, `cnt`, `data_o`, `rise_o`, `fall_o` (and `evt_o` if present) are cleared to 0.
  - Reset asserted during PENDING discards the pending change.
  - On the first edge after reset deasserts, `s[0]` resamples `async_i`. An input held at 1 through reset produces a `rise_o` pulse after the normal latency.

## Timing
- `async_i[i]` changes and is stable before edge 1, then:
  - `y` is new after edge `sync_stages_p`.
  - `data_o[i]` updates at edge `sync_stages_p + filter_cycles_p`.
- `rise_o` / `fall_o` are high for exactly the cycle following that edge, coincident with the first cycle of the new `data_o` value.
- Default parameters: latency is 6 cycles.
- All outputs are registered; there is no combinational path from `async_i` or `evt_clr_i` to any output.

## Configuration
- Macro: `BSG_SYNC_FILTER_EVENT_EN`.
- Defined:
  - Adds `evt_o` and `evt_clr_i`.
  - On each edge, `evt_o[i] <= (evt_o[i] & ~evt_clr_i[i]) | rise_o_next[i] | fall_o_next[i]`; a set on the same edge as a clear wins.
  - `evt_o` resets to 0.
- Undefined: both ports and the sticky register are absent; all other behaviour is identical.

## Test plan
- Reset: `width_p=4`, `sync_stages_p=2`, `filter_cycles_p=4`; `async_i=4'hF` held through 3 reset cycles → `data_o=0`, `rise_o=0`, `fall_o=0` during reset. After deassert, `data_o=4'hF` and `rise_o=4'hF` for one cycle exactly 6 edges later.
- Glitch: `async_i[0]` pulses high for 3 cycles, then low → `data_o[0]` and `rise_o[0]` stay 0. A 4-cycle pulse is accepted: `rise_o[0]` fires, and `fall_o[0]` fires once the input has been low for 4 cycles.
- Chatter: `async_i[1]` toggles every 2 cycles for 40 cycles, then holds 1 → no pulses during chatter. Exactly one `rise_o[1]`, 6 edges after the final hold begins.
- Reset mid-pending: `reset_i` asserted with `cnt=2` on channel 2 → all state is 0 the next cycle and no pulse is emitted. The change is re-accepted with full latency after release.
- Corner parameters: `filter_cycles_p=1`, `sync_stages_p=3` → `data_o` lags `async_i` by exactly 4 edges, and every accepted transition produces one pulse.
- With `BSG_SYNC_FILTER_EVENT_EN`:
  - `rise_o[3]` sets `evt_o[3]`, which holds until `evt_clr_i[3]` is pulsed, then clears on the next edge.
  - `evt_clr_i[3]` asserted on the same edge as a new `fall_o[3]` acceptance → `evt_o[3]` stays 1.

Source files
------------

// File: rtl/bsg_sync_filter_if.sv
// bsg_sync_filter_if
// Bundles the per-channel level input and the filtered outputs of
// bsg_sync_filter.
// Optional sticky-event signals are present when BSG_SYNC_FILTER_EVENT_EN
// is defined.
interface bsg_sync_filter_if #(
  parameter int width_p = 8
);

  logic [width_p-1:0] async_i;
  logic [width_p-1:0] data_o;
  logic [width_p-1:0] rise_o;
  logic [width_p-1:0] fall_o;
`ifdef BSG_SYNC_FILTER_EVENT_EN
  logic [width_p-1:0] evt_o;
  logic [width_p-1:0] evt_clr_i;
`endif

  // Source side: drives the raw levels and consumes the conditioned result.
  modport master (
`ifdef BSG_SYNC_FILTER_EVENT_EN
    output evt_clr_i,
    input  evt_o,
`endif
    output async_i,
    input  data_o,
    input  rise_o,
    input  fall_o
  );

  // Filter side.
  modport slave (
`ifdef BSG_SYNC_FILTER_EVENT_EN
    input  evt_clr_i,
    output evt_o,
`endif
    input  async_i,
    output data_o,
    output rise_o,
    output fall_o
  );

endinterface

// File: rtl/bsg_sync_filter.sv
// bsg_sync_filter
// Multi-channel synchronizer plus glitch filter for asynchronous level inputs.
// Each channel passes through a sync_stages_p flop chain. The filtered level
// changes only after the synchronized value has differed from it for
// filter_cycles_p consecutive edges. Each accepted change produces a one-cycle
// rise/fall pulse.
// Defining BSG_SYNC_FILTER_EVENT_EN adds sticky per-channel change flags
// (evt_o) with a per-bit clear (evt_clr_i). When a set and a clear land on
// the same edge, the set wins.
module bsg_sync_filter #(
  parameter int width_p         = 8,
  parameter int sync_stages_p   = 2,
  parameter int filter_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  bsg_sync_filter_if.slave   bus
);

  localparam int CNT_W = $clog2(filter_cycles_p + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(filter_cycles_p - 1);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_e;

  logic [sync_stages_p-1:0][width_p-1:0] sync_q;
  logic [width_p-1:0]                    y_s;
  logic [width_p-1:0][CNT_W-1:0]         cnt_q, cnt_d;
  logic [width_p-1:0]                    data_q, data_d;
  logic [width_p-1:0]                    rise_q, rise_d;
  logic [width_p-1:0]                    fall_q, fall_d;
  state_e                                state_s [width_p];

  // Synchronizer chain: stage 0 samples the raw pins, later stages shift.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.async_i;
      for (int k = 1; k < sync_stages_p; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Per-channel filter: count consecutive disagreeing cycles, accept at limit.
  always_comb begin
    y_s    = sync_q[sync_stages_p-1];
    cnt_d  = cnt_q;
    data_d = data_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < width_p; i++) begin
      state_s[i] = (y_s[i] != data_q[i]) ? PENDING : STABLE;
      case (state_s[i])
        STABLE: begin
          cnt_d[i] = '0;
        end
        PENDING: begin
          if (cnt_q[i] == CNT_MAX) begin
            data_d[i] = y_s[i];
            cnt_d[i]  = '0;
            rise_d[i] = y_s[i];
            fall_d[i] = ~y_s[i];
          end else begin
            cnt_d[i]  = cnt_q[i] + CNT_W'(1);
          end
        end
        default: begin
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Filter state and pulse registers; reset drops any pending change.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q  <= '0;
      data_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.rise_o = rise_q;
  assign bus.fall_o = fall_q;

`ifdef BSG_SYNC_FILTER_EVENT_EN
  logic [width_p-1:0] evt_q, evt_d;

  // Sticky event: OR in this edge's accepted change after applying the clear.
  always_comb begin
    evt_d = (evt_q & ~bus.evt_clr_i) | rise_d | fall_d;
  end

  // Event flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign bus.evt_o = evt_q;
`endif

endmodule
